// File: rtl/usb_asp_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
// usb_asp_spi_responder_pkg
// Shared constants and state encoding for the mode-3 SPI responder.
// Revision: 1.0
// ============================================================================
package usb_asp_spi_responder_pkg;

  localparam logic       SPI_CPOL          = 1'b1;
  localparam logic       SPI_CPHA          = 1'b1;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;
  localparam int         SYNC_STAGES_MIN   = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SELECT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/usb_asp_sync_edge.sv
`default_nettype none
// ============================================================================
// usb_asp_sync_edge
// STAGES-flop synchronizer plus history flop producing rise/fall pulses.
// Revision: 1.0
// ============================================================================
module usb_asp_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Preset to the line's idle level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule
`default_nettype wire

// File: rtl/usb_asp_spi_responder.sv
`default_nettype none
// ============================================================================
// usb_asp_spi_responder
// Mode-3 SPI target: MOSI bytes to a sink, MISO bytes from a 1-entry holding reg.
// Revision: 1.0
// ============================================================================
module usb_asp_spi_responder
  import usb_asp_spi_responder_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
  parameter int         SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       frame_start,
  output logic       frame_end,
  output logic       tx_underrun,
  output logic       rx_partial,
  output logic [7:0] byte_count
);

  logic sck_rise, sck_fall, csn_rise, csn_fall;

  usb_asp_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sck (
    .clk    (clk),
    .reset  (reset),
    .d_i    (spi_clk),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  usb_asp_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk    (clk),
    .reset  (reset),
    .d_i    (spi_csn),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // MOSI shares the SCK pipeline depth so it is aligned with sck_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csn_fall) state_d = ST_SELECT;
      ST_SELECT: if (csn_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic miso_q;

  always_comb begin
    spi_miso_oe = 1'b0;
    spi_miso    = 1'b1;
    if (state_q == ST_SELECT) begin
      spi_miso_oe = 1'b1;
      spi_miso    = miso_q;
    end
  end

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_shift_q;
  logic [7:0] tx_shift_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       first_q;
  logic [7:0] rx_data_q, byte_count_q;
  logic       rx_valid_q, rx_first_q, frame_start_q, frame_end_q;
  logic       underrun_q, partial_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 8'd0;
      hold_q        <= 8'd0;
      hold_full_q   <= 1'b0;
      first_q       <= 1'b0;
      miso_q        <= 1'b1;
      rx_data_q     <= 8'd0;
      byte_count_q  <= 8'd0;
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      underrun_q    <= 1'b0;
      partial_q     <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      underrun_q    <= 1'b0;
      partial_q     <= 1'b0;

      // A load and an accept never collide: a load only empties a full register.
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (state_q == ST_IDLE) begin
        if (csn_fall) begin
          frame_start_q <= 1'b1;
          byte_count_q  <= 8'd0;
          bit_cnt_q     <= 3'd0;
          first_q       <= 1'b1;
        end
      end else if (csn_rise) begin
        frame_end_q <= 1'b1;
        partial_q   <= (bit_cnt_q != 3'd0);
        bit_cnt_q   <= 3'd0;
        miso_q      <= 1'b1;
      end else begin
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            if (hold_full_q) begin
              miso_q      <= hold_q[7];
              tx_shift_q  <= {hold_q[6:0], 1'b0};
              hold_full_q <= 1'b0;
            end else begin
              miso_q     <= IDLE_BYTE[7];
              tx_shift_q <= {IDLE_BYTE[6:0], 1'b0};
              underrun_q <= 1'b1;
            end
          end else begin
            miso_q     <= tx_shift_q[7];
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        if (sck_rise) begin
          rx_shift_q <= {rx_shift_q[5:0], mosi_s};
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_q  <= {rx_shift_q, mosi_s};
            rx_valid_q <= 1'b1;
            rx_first_q <= first_q;
            first_q    <= 1'b0;
            if (byte_count_q != 8'hFF) byte_count_q <= byte_count_q + 8'd1;
          end
        end
      end
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_first    = rx_first_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign tx_underrun = underrun_q;
  assign rx_partial  = partial_q;
  assign byte_count  = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_asp_spi_responder.sv
`default_nettype none
// ============================================================================
// tb_usb_asp_spi_responder
// Bit-level SPI master, tx byte feeder and pulse monitor around the responder.
// Revision: 1.0
// ============================================================================
module tb_usb_asp_spi_responder;

  localparam int         HALF = 6;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b1;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_first;
  logic       frame_start, frame_end, tx_underrun, rx_partial;
  logic [7:0] rx_data, byte_count;

  always #5 clk = ~clk;

  usb_asp_spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk     (spi_clk),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_first    (rx_first),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .tx_underrun (tx_underrun),
    .rx_partial  (rx_partial),
    .byte_count  (byte_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] txq[$];
  logic [7:0] rx_got[$];
  logic       rxf_got[$];
  logic [7:0] miso_rd[$];
  int         fs_cnt, fe_cnt, ur_cnt, rp_cnt, oe_err;

  // Byte source: tx_ready is stable between posedges, so checking it at the
  // negedge tells whether the handshake completes on the next posedge.
  initial begin
    logic pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tx_valid = 1'b0;
        pending  = 1'b0;
      end else begin
        if (pending) begin
          tx_valid = 1'b0;
          pending  = 1'b0;
        end
        if (!tx_valid && txq.size() > 0) begin
          tx_data  = txq.pop_front();
          tx_valid = 1'b1;
        end
        if (tx_valid && tx_ready) pending = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_valid) begin
          rx_got.push_back(rx_data);
          rxf_got.push_back(rx_first);
        end
        if (frame_start) fs_cnt++;
        if (frame_end)   fe_cnt++;
        if (tx_underrun) ur_cnt++;
        if (rx_partial)  rp_cnt++;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_got.delete();
    rxf_got.delete();
    miso_rd.delete();
    fs_cnt = 0; fe_cnt = 0; ur_cnt = 0; rp_cnt = 0; oe_err = 0;
  endtask

  // Master: drives MOSI on SCK fall, samples MISO just before SCK rise.
  task automatic spi_frame(input logic [7:0] mosi_b[$], input int nbits);
    logic [7:0] rd;
    logic [7:0] b;
    rd = 8'd0;
    spi_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      b = mosi_b[i/8];
      spi_clk  = 1'b0;
      spi_mosi = b[7 - (i % 8)];
      wait_clk(HALF);
      if (spi_miso_oe !== 1'b1) oe_err++;
      rd = {rd[6:0], spi_miso};
      spi_clk = 1'b1;
      if (i % 8 == 7) miso_rd.push_back(rd);
      wait_clk(HALF);
    end
    spi_csn = 1'b1;
    wait_clk(HALF + 4);
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_cmp++; if (spi_miso !== 1'b1)    begin n_bad++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    n_cmp++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
    n_cmp++; if (tx_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    n_cmp++; if (rx_data !== 8'h00)    begin n_bad++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_cmp++; if (byte_count !== 8'h00) begin n_bad++; $display("FAIL reset_byte_count got %h want 00", byte_count); end
    n_cmp++; if ({rx_valid, frame_start, frame_end, tx_underrun, rx_partial} !== 5'b0)
      begin n_bad++; $display("FAIL reset_pulses got %b want 00000",
                              {rx_valid, frame_start, frame_end, tx_underrun, rx_partial}); end
    reset = 1'b0;
    wait_clk(6);
    n_cmp++; if (fs_cnt + fe_cnt !== 0) begin n_bad++; $display("FAIL reset_release_edges got %0d want 0", fs_cnt + fe_cnt); end
  endtask

  task automatic test_single();
    logic [7:0] m[$];
    clear_mon();
    txq.push_back(8'hA5);
    wait_clk(5);
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL preload_tx_ready got %b want 0", tx_ready); end
    m = '{8'h3C};
    spi_frame(m, 8);
    n_cmp++; if (miso_rd.size() != 1 || miso_rd[0] !== 8'hA5)
      begin n_bad++; $display("FAIL single_miso got %p want A5", miso_rd); end
    n_cmp++; if (rx_got.size() != 1 || rx_got[0] !== 8'h3C || rxf_got[0] !== 1'b1)
      begin n_bad++; $display("FAIL single_rx got %p first %p want 3c first 1", rx_got, rxf_got); end
    n_cmp++; if (byte_count !== 8'd1) begin n_bad++; $display("FAIL single_byte_count got %0d want 1", byte_count); end
    n_cmp++; if (fs_cnt != 1 || fe_cnt != 1)
      begin n_bad++; $display("FAIL single_frame_pulses got fs=%0d fe=%0d want 1/1", fs_cnt, fe_cnt); end
    n_cmp++; if (ur_cnt != 0 || oe_err != 0)
      begin n_bad++; $display("FAIL single_underrun_oe got ur=%0d oe_err=%0d want 0/0", ur_cnt, oe_err); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL single_tx_ready got %b want 1", tx_ready); end
  endtask

  // Randomized and directed frames share one reference: the master reads the
  // fed tx stream in order, then IDLE once it runs dry; MOSI bytes come back verbatim.
  task automatic run_checked_frame(input string tag, input logic [7:0] mosi_b[$],
                                   input logic [7:0] tx_b[$]);
    int nb;
    logic [7:0] exp_rd;
    nb = mosi_b.size();
    clear_mon();
    foreach (tx_b[k]) txq.push_back(tx_b[k]);
    wait_clk(5);
    spi_frame(mosi_b, nb * 8);
    n_cmp++; if (miso_rd.size() != nb || rx_got.size() != nb)
      begin n_bad++; $display("FAIL %s_count got rd=%0d rx=%0d want %0d", tag, miso_rd.size(), rx_got.size(), nb); end
    else begin
      for (int k = 0; k < nb; k++) begin
        exp_rd = (k < tx_b.size()) ? tx_b[k] : IDLE;
        n_cmp++; if (miso_rd[k] !== exp_rd)
          begin n_bad++; $display("FAIL %s_miso[%0d] got %h want %h", tag, k, miso_rd[k], exp_rd); end
        n_cmp++; if (rx_got[k] !== mosi_b[k] || rxf_got[k] !== (k == 0))
          begin n_bad++; $display("FAIL %s_rx[%0d] got %h/%b want %h/%b", tag, k, rx_got[k], rxf_got[k], mosi_b[k], k == 0); end
      end
    end
    n_cmp++; if (byte_count !== 8'(nb)) begin n_bad++; $display("FAIL %s_byte_count got %0d want %0d", tag, byte_count, nb); end
    n_cmp++; if (ur_cnt != nb - tx_b.size())
      begin n_bad++; $display("FAIL %s_underrun got %0d want %0d", tag, ur_cnt, nb - tx_b.size()); end
    n_cmp++; if (fs_cnt != 1 || fe_cnt != 1 || rp_cnt != 0 || oe_err != 0)
      begin n_bad++; $display("FAIL %s_frame got fs=%0d fe=%0d rp=%0d oe_err=%0d want 1/1/0/0", tag, fs_cnt, fe_cnt, rp_cnt, oe_err); end
  endtask

  task automatic test_multi();
    logic [7:0] m[$];
    logic [7:0] t[$];
    m = '{8'h9F, 8'h00, 8'h00, 8'h00};
    t = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_checked_frame("multi", m, t);
  endtask

  task automatic test_underrun();
    logic [7:0] m[$];
    logic [7:0] t[$];
    m = '{8'($urandom), 8'($urandom)};
    t = {};
    run_checked_frame("underrun", m, t);
  endtask

  task automatic test_partial();
    logic [7:0] m[$];
    clear_mon();
    m = '{8'hB7};
    spi_frame(m, 5);
    n_cmp++; if (rp_cnt != 1 || fe_cnt != 1 || rx_got.size() != 0)
      begin n_bad++; $display("FAIL partial_flags got rp=%0d fe=%0d rx=%0d want 1/1/0", rp_cnt, fe_cnt, rx_got.size()); end
    n_cmp++; if (byte_count !== 8'd0) begin n_bad++; $display("FAIL partial_byte_count got %0d want 0", byte_count); end
    clear_mon();
    m = '{8'h55};
    spi_frame(m, 8);
    n_cmp++; if (rx_got.size() != 1 || rx_got[0] !== 8'h55 || rp_cnt != 0)
      begin n_bad++; $display("FAIL partial_next_rx got %p rp=%0d want 55 rp=0", rx_got, rp_cnt); end
    n_cmp++; if (byte_count !== 8'd1) begin n_bad++; $display("FAIL partial_next_byte_count got %0d want 1", byte_count); end
  endtask

  task automatic test_idle_sck();
    int bad;
    bad = 0;
    clear_mon();
    for (int i = 0; i < 40; i++) begin
      spi_clk  = ~spi_clk;
      spi_mosi = 1'($urandom);
      wait_clk(HALF);
      if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) bad++;
    end
    spi_clk = 1'b1;
    wait_clk(HALF);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL idle_sck_pins got %0d bad samples want 0", bad); end
    n_cmp++; if (rx_got.size() != 0 || fs_cnt != 0 || ur_cnt != 0)
      begin n_bad++; $display("FAIL idle_sck_events got rx=%0d fs=%0d ur=%0d want 0/0/0", rx_got.size(), fs_cnt, ur_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    logic [7:0] t[$];
    int nb, ntx;
    for (int f = 0; f < 4; f++) begin
      nb  = $urandom_range(1, 5);
      ntx = $urandom_range(0, nb);
      m = {};
      t = {};
      for (int k = 0; k < nb; k++)  m.push_back(8'($urandom));
      for (int k = 0; k < ntx; k++) t.push_back(8'($urandom));
      run_checked_frame("random", m, t);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] m[$];
    spi_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 3; i++) begin
      spi_clk = 1'b0; spi_mosi = 1'($urandom); wait_clk(HALF);
      spi_clk = 1'b1; wait_clk(HALF);
    end
    reset = 1'b1;
    wait_clk(2);
    n_cmp++; if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || tx_ready !== 1'b1)
      begin n_bad++; $display("FAIL midreset_pins got miso=%b oe=%b rdy=%b want 1/0/1", spi_miso, spi_miso_oe, tx_ready); end
    n_cmp++; if (rx_data !== 8'h00 || byte_count !== 8'h00)
      begin n_bad++; $display("FAIL midreset_regs got rx=%h cnt=%h want 00/00", rx_data, byte_count); end
    spi_csn = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(8);
    clear_mon();
    m = '{8'hC3};
    spi_frame(m, 8);
    n_cmp++; if (rx_got.size() != 1 || rx_got[0] !== 8'hC3 || rp_cnt != 0)
      begin n_bad++; $display("FAIL midreset_rx got %p rp=%0d want c3 rp=0", rx_got, rp_cnt); end
    n_cmp++; if (byte_count !== 8'd1) begin n_bad++; $display("FAIL midreset_byte_count got %0d want 1", byte_count); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_multi();
    test_underrun();
    test_partial();
    test_idle_sck();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_asp_spi_responder.md
Name: usb_asp_spi_responder

Overview:
SPI target (responder) for the SPI master driven by the USB vendor control endpoint. It accepts mode-3 SPI frames (SCK idle high, chip select active-low) and streams each received MOSI byte to a byte sink. Each MISO byte comes from a single-entry transmit holding register filled by a byte source. It serves as an on-chip flash/peripheral stand-in for loopback testing of the bootloader SPI path, and as a slave port in target designs.

Parameters:
IDLE_BYTE, 8'hFF, byte shifted out on MISO when no transmit byte is held (underrun)
SYNC_STAGES, 2, synchronizer flops on spi_clk/spi_csn/spi_mosi (min 2)

Ports:
clk  input  1  system clock; all logic in this domain
reset  input  1  asynchronous, active-high reset
spi_clk  input  1  SPI clock from master, idle high
spi_csn  input  1  chip select, active-low
spi_mosi  input  1  master-out data, MSB first
spi_miso  output  1  target-out data, MSB first
spi_miso_oe  output  1  MISO output enable (high while selected)
tx_data  input  8  next byte to shift out
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; transfer occurs when tx_valid && tx_ready
rx_data  output  8  last received byte
rx_valid  output  1  one-clk pulse, rx_data valid
rx_first  output  1  qualifies rx_valid: first byte of the frame
frame_start  output  1  one-clk pulse on synchronized CSN fall
frame_end  output  1  one-clk pulse on synchronized CSN rise
tx_underrun  output  1  one-clk pulse when IDLE_BYTE is loaded
rx_partial  output  1  one-clk pulse when CSN rises with 1..7 bits received
byte_count  output  8  bytes completed in the current/last frame, saturating at 255

Behaviour:
- Reset values:
  - spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_data=0.
  - All pulses 0, byte_count=0.
  - Bit counter 0, holding register empty.
  - Synchronizers preset to idle: SCK=1, CSN=1, MOSI=0.
- Input conditioning:
  - SYNC_STAGES-flop synchronizers, then one history flop for edge detection.
  - Rise, fall and CSN edges are detected SYNC_STAGES+1 clk after the pin edge.
  - Requirement on master: SCK high and low phases each ≥ SYNC_STAGES+2 clk.
  - Requirement on master: CSN-fall to first SCK fall ≥ SYNC_STAGES+2 clk.
- States:
  - IDLE: CSN high. MISO=1, oe=0.
  - SELECT: entered on CSN fall. Pulse frame_start, clear byte_count, bit_cnt=0, set first-byte flag, oe=1.
  - SELECT exits to IDLE on CSN rise, with the actions below.
- MISO (mode 3):
  - On each synchronized SCK fall in SELECT with bit_cnt==0, load the shift register and drive its MSB.
  - The loaded byte is the held byte if present; tx_ready then rises next clk.
  - If no byte is held, load IDLE_BYTE and pulse tx_underrun.
  - On other SCK falls, shift left and drive the new MSB.
  - A byte presented with tx_valid on the same clk as the load is not used for this byte. It is accepted into the now-empty register.
- MOSI:
  - On each synchronized SCK rise in SELECT, shift in spi_mosi and increment bit_cnt (mod 8).
  - On the 8th rise: rx_data is updated and rx_valid pulses 1 clk later.
  - rx_first=1 for the first byte after frame_start only.
  - byte_count increments, saturating at 255.
  - There is no rx backpressure; the sink must accept every pulse.
- CSN rise:
  - Pulse frame_end. If bit_cnt≠0, pulse rx_partial and discard the partial byte (no rx_valid).
  - bit_cnt=0; MISO=1, oe=0. The holding register is kept (it is preloadable before the next frame).
  - byte_count holds until the next frame_start.
- SCK edges while CSN is high are ignored.
- CSN fall and rise within one clk (glitch) are not supported; the last synchronized value wins.
- Asynchronous reset mid-frame returns everything to reset values immediately. The frame resumes only after a fresh CSN fall.

Decomposition:
- Shared package: SPI mode constant (CPOL=1, CPHA=1), IDLE_BYTE default, state encodings IDLE/SELECT.
- One natural sub-module: usb_asp_sync_edge. It is an N-stage synchronizer with rise/fall pulse outputs, instanced for spi_clk and spi_csn; spi_mosi uses the synchronizer only.

Test Plan:
- Preload tx 8'hA5, then a 1-byte frame with MOSI 8'h3C at SCK period 12 clk -> MISO bits 1,0,1,0,0,1,0,1 at rising edges; rx_data=8'h3C, rx_valid=1 pulse, rx_first=1, byte_count=1, frame_start and frame_end one pulse each.
- 4-byte frame with tx stream 8'h01..8'h04 fed on tx_ready; MOSI 8'h9F,00,00,00 -> master reads 01,02,03,04; rx_first only on 8'h9F; byte_count=4; no tx_underrun.
- Frame with no tx byte held -> master reads 8'hFF; tx_underrun pulses once per byte.
- CSN rises after 5 bits -> rx_partial=1 pulse, no rx_valid; next frame starts at bit 0 and receives 8'h55 correctly.
- SCK toggling with CSN high -> no rx_valid, spi_miso_oe=0, spi_miso=1.
- Assert reset mid-byte (bit 3), release, start a new frame -> outputs at reset values during reset; new frame receives 8'hC3 correctly and byte_count=1.
